adc_capture: RTL and testbench

- Triggered capture engine for the dual 8-bit ADC sample stream.
- Writes {adc_a_d, adc_b_d} words into a 4096 x 16 circular buffer, with a programmable pre-trigger depth and decimation.
- Exposes a synchronous read port that the SPI module drives via mem_addr/mem_data, so the MCU can upload a completed record.
- Sits directly upstream of the SPI module; configured by the 32-bit adc_cfg word.

---
 rtl/adc_capture_if.sv | 27 ++
 rtl/adc_capture.sv | 170 +++++++++++++++++
 tb/tb_adc_capture.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_if.sv
// Sample, configuration and read-back bundle between adc_capture (slave) and its
// controller / SPI read-out side (master).
interface adc_capture_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] adc_data;
    logic [31:0]       cfg;
    logic              arm;
    logic              force_trig;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic              trig_auto;

    modport master (
        output adc_data, cfg, arm, force_trig, rd_addr,
        input  rd_data, busy, done, trig_addr, trig_auto
    );

    modport slave (
        input  adc_data, cfg, arm, force_trig, rd_addr,
        output rd_data, busy, done, trig_addr, trig_auto
    );
endinterface

// File: rtl/adc_capture.sv
// Triggered capture of the decimated {A,B} sample stream into a circular RAM with pre-trigger depth.
// Defining ADC_CAPTURE_AUTO_TRIG_EN adds a timeout trigger after AUTO_TICKS ticks in WAIT_TRIG.
module adc_capture #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int AUTO_TICKS = 65536
) (
    input  logic         clk,
    input  logic         reset,
    adc_capture_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT_TRIG, S_POST, S_DONE} state_t;

    state_t            state_q;
    logic [7:0]        decim_q, decim_cnt_q, level_q, prev_q;
    logic              src_b_q, fall_q, prev_valid_q;
    logic [ADDR_W-1:0] pretrig_q, pre_cnt_q, post_rem_q, wr_ptr_q, trig_addr_q;
    logic              busy_q, done_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              tick, wr_en, level_hit, auto_hit, trig_fire;
    logic [7:0]        cur;
    logic [ADDR_W-1:0] post_len;

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    localparam int AUTO_W = $clog2(AUTO_TICKS + 1);
    logic [AUTO_W-1:0] auto_cnt_q;
    logic              trig_auto_q;
    logic              unused_bits;
    assign unused_bits   = ^bus.cfg[11:10];
    assign bus.trig_auto = trig_auto_q;
`else
    logic unused_bits;
    assign unused_bits   = ^{bus.cfg[11:10], AUTO_TICKS[0]};
    assign bus.trig_auto = 1'b0;
`endif

    // NOTE: every signal written here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        tick      = (decim_cnt_q == decim_q);
        wr_en     = tick && (state_q inside {S_PRE, S_WAIT_TRIG, S_POST});
        cur       = src_b_q ? bus.adc_data[7:0] : bus.adc_data[DATA_W-1 -: 8];
        level_hit = prev_valid_q && (fall_q ? (prev_q >= level_q && cur <  level_q)
                                            : (prev_q <  level_q && cur >= level_q));
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        auto_hit  = (auto_cnt_q == AUTO_W'(AUTO_TICKS - 1));
`else
        auto_hit  = 1'b0;
`endif
        trig_fire = tick && (state_q == S_WAIT_TRIG) && (level_hit || bus.force_trig || auto_hit);
        post_len  = ADDR_W'(DEPTH - 1) - pretrig_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            decim_q      <= '0;
            decim_cnt_q  <= '0;
            level_q      <= '0;
            prev_q       <= '0;
            src_b_q      <= 1'b0;
            fall_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            pretrig_q    <= '0;
            pre_cnt_q    <= '0;
            post_rem_q   <= '0;
            wr_ptr_q     <= '0;
            trig_addr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
            auto_cnt_q   <= '0;
            trig_auto_q  <= 1'b0;
`endif
        end else begin
            decim_cnt_q <= tick ? 8'd0 : decim_cnt_q + 8'd1;
            if (wr_en) begin
                wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
                prev_q       <= cur;
                prev_valid_q <= 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.arm) begin
                        level_q      <= bus.cfg[7:0];
                        src_b_q      <= bus.cfg[8];
                        fall_q       <= bus.cfg[9];
                        pretrig_q    <= ADDR_W'(bus.cfg[23:12]);
                        decim_q      <= bus.cfg[31:24];
                        decim_cnt_q  <= '0;
                        wr_ptr_q     <= '0;
                        pre_cnt_q    <= '0;
                        prev_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
                        auto_cnt_q   <= '0;
                        trig_auto_q  <= 1'b0;
`endif
                        state_q      <= (bus.cfg[23:12] == 12'd0) ? S_WAIT_TRIG : S_PRE;
                    end
                end
                S_PRE: begin
                    if (tick) begin
                        pre_cnt_q <= pre_cnt_q + ADDR_W'(1);
                        if (pre_cnt_q + ADDR_W'(1) == pretrig_q) begin
                            state_q <= S_WAIT_TRIG;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
                            auto_cnt_q <= '0;
`endif
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (trig_fire) begin
                        // The trigger sample is written this tick at the current write pointer.
                        trig_addr_q <= wr_ptr_q;
                        post_rem_q  <= post_len;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
                        trig_auto_q <= auto_hit && !level_hit && !bus.force_trig;
`endif
                        if (post_len == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_POST;
                        end
                    end
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
                    else if (tick) begin
                        auto_cnt_q <= auto_cnt_q + AUTO_W'(1);
                    end
`endif
                end
                S_POST: begin
                    if (tick) begin
                        post_rem_q <= post_rem_q - ADDR_W'(1);
                        if (post_rem_q == ADDR_W'(1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: the sample RAM has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.adc_data;
    end

    // Read-before-write: a same-cycle read of the write address returns the previous word.
    always_ff @(posedge clk) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= mem[bus.rd_addr];
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.trig_addr = trig_addr_q;
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: directed capture table, reset/abort sequences, and random captures checked
// against a sample-list reference model. Auto-trigger expectations follow ADC_CAPTURE_AUTO_TRIG_EN.
module tb_adc_capture;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4096;
    localparam int STIM_N = 17000;
    localparam logic [31:0] ALT_CFG = 32'h0000_0020;

    typedef enum int {ST_RAMP, ST_COUNT, ST_CONST, ST_RAND} stim_kind_t;

    typedef struct {
        string       name;
        logic [31:0] cfg;
        stim_kind_t  kind;
        bit          frc;
        int          disturb_at;
        logic [11:0] exp_trig;
        int          exp_busy;
        logic [15:0] exp_at_trig;
        logic [15:0] exp_before_trig;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] stim [STIM_N];

    always #5 clk = ~clk;

    adc_capture_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    adc_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_TICKS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_cfg(input logic [7:0] lvl, input logic src_b, input logic fall,
                                           input logic [11:0] pre, input logic [7:0] dec);
        return {dec, pre, 2'b00, fall, src_b, lvl};
    endfunction

    function automatic logic [7:0] chan_of(input logic [15:0] s, input logic src_b);
        return src_b ? s[7:0] : s[15:8];
    endfunction

    task automatic fill_stim(input stim_kind_t kind);
        for (int c = 0; c < STIM_N; c++) begin
            logic [7:0] lo;
            lo = 8'(c);
            case (kind)
                ST_RAMP:  stim[c] = {lo, ~lo};
                ST_COUNT: stim[c] = 16'(c);
                ST_CONST: stim[c] = 16'h5A5A;
                default:  stim[c] = 16'($urandom);
            endcase
        end
    endtask

    // Arms on one edge, then presents stim[c] before the c-th following edge.
    task automatic run_capture(input logic [31:0] c_cfg, input bit frc, input int disturb_at,
                               input bit do_reset, input int max_clks,
                               output int busy_clks, output bit finished);
        busy_clks = 0;
        finished  = 1'b0;
        @(negedge clk);
        bus.cfg        = c_cfg;
        bus.arm        = 1'b1;
        bus.force_trig = frc;
        bus.adc_data   = stim[0];
        for (int c = 1; c <= max_clks; c++) begin
            @(negedge clk);
            bus.arm = 1'b0;
            if (bus.busy) busy_clks++;
            if (bus.done) begin
                finished = 1'b1;
                break;
            end
            if (c == disturb_at) begin
                if (do_reset) begin
                    reset = 1'b1;
                    break;
                end
                bus.arm = 1'b1;
                bus.cfg = ALT_CFG;
            end
            bus.adc_data = stim[c];
        end
        bus.force_trig = 1'b0;
    endtask

    task automatic read_mem(input logic [11:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.rd_addr = a;
        @(negedge clk);
        d = bus.rd_data;
    endtask

    // Reference: the k-th tick after arm sees stim[(decim+1)*(k+1)]; trigger is the first sample at
    // index >= pretrig whose edge condition holds against the previous sample; 4095-pretrig follow it.
    task automatic model_capture(input logic [31:0] c, output int trig_k, output int n_wr);
        int d, pre;
        d      = int'(c[31:24]);
        pre    = int'(c[23:12]);
        trig_k = -1;
        for (int k = pre; (d + 1) * (k + 1) < STIM_N; k++) begin
            if (k >= 1) begin
                logic [7:0] p, q;
                p = chan_of(stim[(d + 1) * k], c[8]);
                q = chan_of(stim[(d + 1) * (k + 1)], c[8]);
                if (c[9] ? (p >= c[7:0] && q < c[7:0]) : (p < c[7:0] && q >= c[7:0])) begin
                    trig_k = k;
                    break;
                end
            end
        end
        n_wr = trig_k + 1 + (DEPTH - 1 - pre);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " busy"},      32'(bus.busy),      32'd0);
        check({tag, " done"},      32'(bus.done),      32'd0);
        check({tag, " trig_addr"}, 32'(bus.trig_addr), 32'd0);
        check({tag, " trig_auto"}, 32'(bus.trig_auto), 32'd0);
        check({tag, " rd_data"},   32'(bus.rd_data),   32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int   bc;
        bit   fin;
        logic [15:0] rd;

        vecs[0] = '{"pre256_rise_a",  mk_cfg(8'h80, 1'b0, 1'b0, 12'h100, 8'd0), ST_RAMP,  1'b0, 0,
                    12'h17F, 4223,  16'h807F, 16'h7F80};
        vecs[1] = '{"decim3_force",   mk_cfg(8'h00, 1'b0, 1'b0, 12'h000, 8'd3), ST_COUNT, 1'b1, 0,
                    12'h000, 16384, 16'h0004, 16'h4000};
        vecs[2] = '{"pre4095_fall_b", mk_cfg(8'h40, 1'b1, 1'b1, 12'hFFF, 8'd0), ST_RAMP,  1'b0, 0,
                    12'h0BF, 4288,  16'hC03F, 16'hBF40};
        vecs[3] = '{"arm_while_busy", mk_cfg(8'h80, 1'b0, 1'b0, 12'h100, 8'd0), ST_RAMP,  1'b0, 50,
                    12'h17F, 4223,  16'h807F, 16'h7F80};

        // Reset with arm held high: reset must win.
        reset          = 1'b1;
        bus.arm        = 1'b1;
        bus.cfg        = mk_cfg(8'h10, 1'b0, 1'b0, 12'h000, 8'd0);
        bus.force_trig = 1'b0;
        bus.adc_data   = 16'h0000;
        bus.rd_addr    = 12'h123;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset   = 1'b0;
        bus.arm = 1'b0;
        @(negedge clk);
        check("arm_with_reset busy", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 4; i++) begin
            fill_stim(vecs[i].kind);
            run_capture(vecs[i].cfg, vecs[i].frc, vecs[i].disturb_at, 1'b0, STIM_N - 1, bc, fin);
            check({vecs[i].name, " done"},      32'(fin),           32'd1);
            check({vecs[i].name, " busy_low"},  32'(bus.busy),      32'd0);
            check({vecs[i].name, " trig_addr"}, 32'(bus.trig_addr), 32'(vecs[i].exp_trig));
            check({vecs[i].name, " trig_auto"}, 32'(bus.trig_auto), 32'd0);
            check({vecs[i].name, " busy_clks"}, 32'(bc),            32'(vecs[i].exp_busy));
            read_mem(vecs[i].exp_trig, rd);
            check({vecs[i].name, " mem_trig"},  32'(rd), 32'(vecs[i].exp_at_trig));
            read_mem(vecs[i].exp_trig - 12'd1, rd);
            check({vecs[i].name, " mem_before"}, 32'(rd), 32'(vecs[i].exp_before_trig));
            repeat (3) @(negedge clk);
            check({vecs[i].name, " done_held"}, 32'(bus.done), 32'd1);
        end

        // Reset in the middle of the post-trigger phase aborts the capture.
        fill_stim(ST_RAMP);
        run_capture(vecs[0].cfg, 1'b0, 1000, 1'b1, STIM_N - 1, bc, fin);
        check("mid_post busy_clks", 32'(bc), 32'd1000);
        @(negedge clk);
        check_reset_values("mid_post_reset");
        reset = 1'b0;

        // Random captures against the model.
        for (int r = 0; r < 3; r++) begin
            logic [31:0] rc;
            int tk, nw, d;
            fill_stim(ST_RAND);
            rc = mk_cfg(8'($urandom_range(16, 240)), 1'($urandom), 1'($urandom), 12'($urandom),
                        8'($urandom_range(0, 1)));
            d = int'(rc[31:24]);
            model_capture(rc, tk, nw);
            run_capture(rc, 1'b0, 0, 1'b0, STIM_N - 1, bc, fin);
            check("rand done",      32'(fin),           32'd1);
            check("rand trig_addr", 32'(bus.trig_addr), 32'(tk % DEPTH));
            check("rand busy_clks", 32'(bc),            32'((d + 1) * nw));
            for (int n = 0; n < 24; n++) begin
                int a, j;
                a = (n == 0) ? (tk % DEPTH) : int'($urandom_range(0, DEPTH - 1));
                j = a + DEPTH * ((nw - 1 - a) / DEPTH);
                read_mem(12'(a), rd);
                check("rand mem", 32'(rd), 32'(stim[(d + 1) * (j + 1)]));
            end
        end

        // Constant input, pretrig 0: only a timeout can trigger.
        fill_stim(ST_CONST);
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
        run_capture(mk_cfg(8'h40, 1'b0, 1'b0, 12'h000, 8'd0), 1'b0, 0, 1'b0, 8000, bc, fin);
        check("auto done",      32'(fin),           32'd1);
        check("auto trig_addr", 32'(bus.trig_addr), 32'd15);
        check("auto trig_auto", 32'(bus.trig_auto), 32'd1);
        check("auto busy_clks", 32'(bc),            32'd4111);
        read_mem(12'd15, rd);
        check("auto mem_trig",  32'(rd),            32'h5A5A);
`else
        run_capture(mk_cfg(8'h40, 1'b0, 1'b0, 12'h000, 8'd0), 1'b0, 0, 1'b0, 2000, bc, fin);
        check("no_auto done",      32'(fin),           32'd0);
        check("no_auto busy",      32'(bus.busy),      32'd1);
        check("no_auto trig_auto", 32'(bus.trig_auto), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("abort_wait");
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
